instr_sequencer: RTL and testbench

Parametrised successor to the combinational instruction decoder. Accepts instruction words (opcode plus argument) over a valid/ready handshake and registers the decoded control strobes. It adds timed and event-released WAIT stalls, a generalised ALU register-enable width, and a retired-instruction counter. It sits between the instruction source (switch loader or program memory) and the ALU/result datapath.

---
 rtl/instr_sequencer.sv | 171 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: valid/ready intake, registered control strobes, timed and event-released WAIT stalls.
// Optional ILLEGAL_OP_TRAP_EN adds a sticky illegal_op flag that halts intake until reset.
module instr_sequencer #(
  parameter int OPCODE_WIDTH = 3,
  parameter int ARG_WIDTH    = 8,
  parameter int NUM_ALU_REGS = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [OPCODE_WIDTH+ARG_WIDTH-1:0] instr,
  input  logic                              instr_valid,
  output logic                              instr_ready,
  input  logic                              wait_release,
  output logic                              f_move,
  output logic                              f_load,
  output logic                              f_clr,
  output logic                              wr_res,
  output logic                              f_wait,
  output logic [NUM_ALU_REGS-1:0]           ALU_reg_en,
  output logic                              busy,
  output logic [CNT_WIDTH-1:0]              retired_cnt
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic                              illegal_op
`endif
);

  localparam logic [OPCODE_WIDTH-1:0] OP_MOV  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_MAC  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_WAIT = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_SETB = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_SETD = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_SETE = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDSW = OPCODE_WIDTH'(6);

  typedef enum logic [1:0] {IDLE, WAIT_CNT, WAIT_EXT} state_t;

  state_t                   state_q, state_d;
  logic [ARG_WIDTH-1:0]     cnt_q, cnt_d;
  logic                     move_q, move_d;
  logic                     load_q, load_d;
  logic                     clr_q, clr_d;
  logic                     wr_q, wr_d;
  logic                     wait_q, wait_d;
  logic                     busy_q, busy_d;
  logic [NUM_ALU_REGS-1:0]  en_q, en_d;
  logic [CNT_WIDTH-1:0]     retired_q, retired_d;
  logic                     illegal_q, illegal_d;

  logic [OPCODE_WIDTH-1:0]  opcode;
  logic [ARG_WIDTH-1:0]     arg;
  logic                     accept;
  logic                     legal;

  assign opcode = instr[OPCODE_WIDTH+ARG_WIDTH-1:ARG_WIDTH];
  assign arg    = instr[ARG_WIDTH-1:0];
  assign legal  = (opcode <= OP_LDSW);

`ifdef ILLEGAL_OP_TRAP_EN
  assign instr_ready = (state_q == IDLE) && !illegal_q;
  assign illegal_op  = illegal_q;
`else
  assign instr_ready = (state_q == IDLE);
`endif

  assign accept = instr_valid && instr_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    move_d    = 1'b0;
    load_d    = 1'b0;
    clr_d     = 1'b0;
    wr_d      = 1'b0;
    en_d      = '0;
    retired_d = retired_q;
    illegal_d = illegal_q;

    case (state_q)
      IDLE: begin
        if (accept && opcode == OP_WAIT) begin
          if (arg != '0) begin
            state_d = WAIT_CNT;
            cnt_d   = arg;
          end else begin
            state_d = WAIT_EXT;
          end
        end
      end
      WAIT_CNT: begin
        // Leaving on count 1 makes the stall exactly arg cycles long.
        if (cnt_q == ARG_WIDTH'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ARG_WIDTH'(1);
        end
      end
      WAIT_EXT: begin
        if (wait_release) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      case (opcode)
        OP_MOV: begin
          move_d = 1'b1;
          clr_d  = 1'b1;
          wr_d   = 1'b1;
          en_d   = '1;
        end
        OP_MAC:  wr_d = 1'b1;
        OP_SETB: en_d = NUM_ALU_REGS'(1);
        OP_SETD: en_d = NUM_ALU_REGS'(2);
        OP_SETE: en_d = NUM_ALU_REGS'(4);
        OP_LDSW: begin
          load_d = 1'b1;
          clr_d  = 1'b1;
          wr_d   = 1'b1;
          en_d   = '1;
        end
        default: ;
      endcase
      if (legal) retired_d = retired_q + CNT_WIDTH'(1);
      else       illegal_d = 1'b1;
    end

    wait_d = (state_d != IDLE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      move_q    <= 1'b0;
      load_q    <= 1'b0;
      clr_q     <= 1'b0;
      wr_q      <= 1'b0;
      wait_q    <= 1'b0;
      busy_q    <= 1'b0;
      en_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      move_q    <= move_d;
      load_q    <= load_d;
      clr_q     <= clr_d;
      wr_q      <= wr_d;
      wait_q    <= wait_d;
      busy_q    <= busy_d;
      en_q      <= en_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  assign f_move      = move_q;
  assign f_load      = load_q;
  assign f_clr       = clr_q;
  assign wr_res      = wr_q;
  assign f_wait      = wait_q;
  assign busy        = busy_q;
  assign ALU_reg_en  = en_q;
  assign retired_cnt = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed scoreboard bench for instr_sequencer (CNT_WIDTH=4); handles the ILLEGAL_OP_TRAP_EN build too.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        wait_release;
  logic        f_move, f_load, f_clr, wr_res, f_wait, busy;
  logic [2:0]  ALU_reg_en;
  logic [3:0]  retired_cnt;
`ifdef ILLEGAL_OP_TRAP_EN
  logic        illegal_op;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  int   m_state = 0;  // 0 idle, 1 counted wait, 2 external wait
  int   m_cnt   = 0;
  int   m_ret   = 0;
  bit   m_ill   = 1'b0;

  logic [12:0] exp_q[$];
  logic        ill_q[$];

  instr_sequencer #(
    .OPCODE_WIDTH(3), .ARG_WIDTH(8), .NUM_ALU_REGS(3), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .wait_release(wait_release),
    .f_move(f_move), .f_load(f_load), .f_clr(f_clr), .wr_res(wr_res),
    .f_wait(f_wait), .ALU_reg_en(ALU_reg_en), .busy(busy),
    .retired_cnt(retired_cnt)
`ifdef ILLEGAL_OP_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [12:0] outs();
    return {f_move, f_load, f_clr, wr_res, f_wait, busy, ALU_reg_en, retired_cnt};
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_ret = 0; m_ill = 1'b0;
    exp_q.delete(); ill_q.delete();
  endtask

  // One clock cycle: drive, check ready, predict, clock, pop and compare.
  task automatic step(input string tag, input logic v, input logic [2:0] op,
                      input logic [7:0] arg, input logic rel);
    logic        rdy, acc, mv, ld, cl, wr;
    logic [2:0]  en;
    logic [12:0] e, got;
    logic        ei;
    instr_valid  = v;
    instr        = {op, arg};
    wait_release = rel;
    @(negedge clk);
    rdy = (m_state == 0) && !m_ill;
    chk({tag, ".ready"}, 16'(instr_ready), 16'(rdy));
    acc = v && rdy;
    mv = 0; ld = 0; cl = 0; wr = 0; en = 3'b000;
    if (acc) begin
      case (op)
        3'd0: begin mv = 1; cl = 1; wr = 1; en = 3'b111; end
        3'd1: wr = 1;
        3'd3: en = 3'b001;
        3'd4: en = 3'b010;
        3'd5: en = 3'b100;
        3'd6: begin ld = 1; cl = 1; wr = 1; en = 3'b111; end
        default: ;
      endcase
    end
    if (m_state == 1) begin
      if (m_cnt == 1) m_state = 0; else m_cnt--;
    end else if (m_state == 2) begin
      if (rel) m_state = 0;
    end else if (acc && op == 3'd2) begin
      if (arg != 0) begin m_state = 1; m_cnt = arg; end
      else m_state = 2;
    end
    if (acc && op != 3'd7) m_ret = (m_ret + 1) % 16;
`ifdef ILLEGAL_OP_TRAP_EN
    if (acc && op == 3'd7) m_ill = 1'b1;
`endif
    e = {mv, ld, cl, wr, (m_state != 0), (m_state != 0), en, 4'(m_ret)};
    exp_q.push_back(e);
    ill_q.push_back(m_ill);
    @(posedge clk);
    #1;
    got = outs();
    e  = exp_q.pop_front();
    ei = ill_q.pop_front();
    chk({tag, ".outs"}, 16'(got), 16'(e));
`ifdef ILLEGAL_OP_TRAP_EN
    chk({tag, ".illegal_op"}, 16'(illegal_op), 16'(ei));
`else
    if (ei !== 1'b0) chk({tag, ".illegal_model"}, 16'(ei), 16'(0));
`endif
    instr_valid  = 1'b0;
    wait_release = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; wait_release = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.outs", 16'(outs()), 16'(0));
    chk("reset.ready", 16'(instr_ready), 16'(1));
    @(negedge clk);
    rst_n = 1'b1;

    step("idle0", 0, 3'd0, 8'd0, 0);
    step("mov",   1, 3'd0, 8'd0, 0);
    step("mov_after", 0, 3'd0, 8'd0, 0);
    step("setb",  1, 3'd3, 8'd0, 0);
    step("setd",  1, 3'd4, 8'd0, 0);
    step("sete",  1, 3'd5, 8'd0, 0);
    step("idle1", 0, 3'd0, 8'd0, 0);

    step("wait5", 1, 3'd2, 8'd5, 0);
    for (int i = 0; i < 6; i++) step("wait5_mac", 1, 3'd1, 8'd0, 0);
    step("after_mac", 0, 3'd0, 8'd0, 0);

    step("idle_rel", 0, 3'd0, 8'd0, 1);
    step("wait0", 1, 3'd2, 8'd0, 0);
    for (int i = 0; i < 20; i++) step("wait0_hold", 0, 3'd0, 8'd0, 0);
    step("wait0_rel", 0, 3'd0, 8'd0, 1);
    step("wait0_done", 0, 3'd0, 8'd0, 0);

    step("ldsw", 1, 3'd6, 8'd0, 0);
    step("mac",  1, 3'd1, 8'd0, 0);
    step("idle2", 0, 3'd0, 8'd0, 0);

    step("wait5b", 1, 3'd2, 8'd5, 0);
    step("wait5b_c4", 0, 3'd0, 8'd0, 0);
    step("wait5b_c3", 0, 3'd0, 8'd0, 0);
    rst_n = 1'b0;
    #1;
    chk("midreset.f_wait", 16'(f_wait), 16'(0));
    chk("midreset.busy", 16'(busy), 16'(0));
    chk("midreset.retired", 16'(retired_cnt), 16'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset", 0, 3'd0, 8'd0, 0);

    for (int i = 0; i < 17; i++) step("mac17", 1, 3'd1, 8'd0, 0);
    chk("mac17.count", 16'(retired_cnt), 16'(1));

    step("illegal", 1, 3'd7, 8'd0, 0);
    step("after_illegal", 1, 3'd1, 8'd0, 0);
    step("idle3", 0, 3'd0, 8'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
